// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Control bundle between the multi-cycle MIPS sequencer and its datapath.
//   master : the sequencer (takes start/opcode/memory-ready, drives enables,
//            mux selects, ALUOp and status).
//   slave  : the datapath side (drives start/opcode/memory-ready, takes the rest).
`timescale 1ns/1ps
interface multicycle_control_if;
  logic       start_i;
  logic [5:0] Op_i;
  logic       mem_ready_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       MemToReg_o;
  logic       RegDst_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic [1:0] PCSource_o;
  logic       inst_done_o;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  start_i, Op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, inst_done_o, illegal_o, state_o
  );

  modport slave (
    output start_i, Op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, inst_done_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencer for a multi-cycle MIPS datapath with one shared
//   instruction/data memory port (variable-latency mem_ready handshake),
//   an IR and a single ALU reused for PC+4, branch target and execute.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset (aborts any instruction at once)
//   bus    - master side of multicycle_control_if:
//            in : start_i (run enable, sampled at instruction boundaries),
//                 Op_i (IR[31:26]), mem_ready_i (memory completes this cycle)
//            out: PC/IR/memory/register enables, mux selects, ALUOp,
//                 inst_done_o (retire pulse), illegal_o (sticky), state_o
`timescale 1ns/1ps
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE     = 6'b000000,
  parameter logic [5:0] OP_LW        = 6'b100011,
  parameter logic [5:0] OP_SW        = 6'b101011,
  parameter logic [5:0] OP_BEQ       = 6'b000100,
  parameter logic [5:0] OP_J         = 6'b000010,
  parameter logic [5:0] OP_ADDI      = 6'b001000,
  parameter bit         ILLEGAL_HALT = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_WB   = 4'd11,
    HALT      = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       retire;

  // Next-state logic. Every retiring state funnels through `retire` so the
  // boundary decision (FETCH vs IDLE on start_i) lives in one place.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      IDLE:      if (bus.start_i) state_d = FETCH;
      FETCH:     if (bus.mem_ready_i) state_d = DECODE;
      DECODE: begin
        // Opcode is captured here so later states never look at live Op_i.
        op_d = bus.Op_i;
        case (bus.Op_i)
          OP_LW, OP_SW:      state_d = MEM_ADDR;
          OP_RTYPE, OP_ADDI: state_d = EXECUTE;
          OP_BEQ:            state_d = BRANCH;
          OP_J:              state_d = JUMP;
          default: begin
            illegal_d = 1'b1;
            if (ILLEGAL_HALT) state_d = HALT;
            else              retire  = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (bus.mem_ready_i) state_d = MEM_WB;
      MEM_WRITE: if (bus.mem_ready_i) retire = 1'b1;
      EXECUTE:   state_d = (op_q == OP_ADDI) ? ADDI_WB : R_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: retire = 1'b1;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
    if (retire) state_d = bus.start_i ? FETCH : IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode: state register only, plus mem_ready_i gating the FETCH
  // enables and the latched opcode selecting the EXECUTE flavour.
  always_comb begin
    bus.PCWrite_o     = 1'b0;
    bus.PCWriteCond_o = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.MemRead_o     = 1'b0;
    bus.MemWrite_o    = 1'b0;
    bus.IRWrite_o     = 1'b0;
    bus.MemToReg_o    = 1'b0;
    bus.RegDst_o      = 1'b0;
    bus.RegWrite_o    = 1'b0;
    bus.ALUSrcA_o     = 1'b0;
    bus.ALUSrcB_o     = 2'b00;
    bus.ALUOp_o       = 2'b00;
    bus.PCSource_o    = 2'b00;
    case (state_q)
      FETCH: begin
        bus.MemRead_o = 1'b1;
        bus.ALUSrcB_o = 2'b01;
        bus.IRWrite_o = bus.mem_ready_i;
        bus.PCWrite_o = bus.mem_ready_i;
      end
      DECODE:    bus.ALUSrcB_o = 2'b11;
      MEM_ADDR: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = 2'b10;
      end
      MEM_READ: begin
        bus.MemRead_o = 1'b1;
        bus.IorD_o    = 1'b1;
      end
      MEM_WRITE: begin
        bus.MemWrite_o = 1'b1;
        bus.IorD_o     = 1'b1;
      end
      MEM_WB: begin
        bus.MemToReg_o = 1'b1;
        bus.RegWrite_o = 1'b1;
      end
      EXECUTE: begin
        bus.ALUSrcA_o = 1'b1;
        if (op_q == OP_ADDI) begin
          bus.ALUSrcB_o = 2'b10;
        end else begin
          bus.ALUOp_o   = 2'b10;
        end
      end
      R_WB: begin
        bus.RegDst_o   = 1'b1;
        bus.RegWrite_o = 1'b1;
      end
      ADDI_WB:   bus.RegWrite_o = 1'b1;
      BRANCH: begin
        bus.ALUSrcA_o     = 1'b1;
        bus.ALUOp_o       = 2'b01;
        bus.PCWriteCond_o = 1'b1;
        bus.PCSource_o    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite_o  = 1'b1;
        bus.PCSource_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.inst_done_o = retire;
  assign bus.illegal_o   = illegal_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1, S_DEC = 4'd2,
                         S_MADDR = 4'd3, S_MREAD = 4'd4, S_MWB = 4'd5,
                         S_MWRITE = 4'd6, S_EXEC = 4'd7, S_RWB = 4'd8,
                         S_BR = 4'd9, S_JMP = 4'd10, S_AWB = 4'd11,
                         S_HALT = 4'd12;

  // ctrl vector: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  //               MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  localparam logic [15:0] C_NONE   = 16'h0000;
  localparam logic [15:0] C_FSTALL = 16'h1010;
  localparam logic [15:0] C_FGO    = 16'h9410;
  localparam logic [15:0] C_DEC    = 16'h0030;
  localparam logic [15:0] C_MADDR  = 16'h0060;
  localparam logic [15:0] C_MREAD  = 16'h3000;
  localparam logic [15:0] C_MWB    = 16'h0280;
  localparam logic [15:0] C_MWRITE = 16'h2800;
  localparam logic [15:0] C_EXEC_R = 16'h0048;
  localparam logic [15:0] C_EXEC_I = 16'h0060;
  localparam logic [15:0] C_RWB    = 16'h0180;
  localparam logic [15:0] C_AWB    = 16'h0080;
  localparam logic [15:0] C_BR     = 16'h4045;
  localparam logic [15:0] C_JMP    = 16'h8002;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000,
                         O_BAD = 6'b111111, DC = 6'b101010;

  logic clk;
  logic rst;

  multicycle_control_if bus0();
  multicycle_control_if bus1();

  multicycle_control #(.ILLEGAL_HALT(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  multicycle_control #(.ILLEGAL_HALT(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  logic [15:0] ctrl0, ctrl1;
  assign ctrl0 = {bus0.PCWrite_o, bus0.PCWriteCond_o, bus0.IorD_o, bus0.MemRead_o,
                  bus0.MemWrite_o, bus0.IRWrite_o, bus0.MemToReg_o, bus0.RegDst_o,
                  bus0.RegWrite_o, bus0.ALUSrcA_o, bus0.ALUSrcB_o, bus0.ALUOp_o,
                  bus0.PCSource_o};
  assign ctrl1 = {bus1.PCWrite_o, bus1.PCWriteCond_o, bus1.IorD_o, bus1.MemRead_o,
                  bus1.MemWrite_o, bus1.IRWrite_o, bus1.MemToReg_o, bus1.RegDst_o,
                  bus1.RegWrite_o, bus1.ALUSrcA_o, bus1.ALUSrcB_o, bus1.ALUOp_o,
                  bus1.PCSource_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [3:0]  state;
    logic [15:0] ctrl;
    logic        done;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned seq   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.sel == 1'b0) begin
        check($sformatf("state#%0d", seq), {28'd0, bus0.state_o}, {28'd0, e.state});
        check($sformatf("ctrl#%0d", seq), {16'd0, ctrl0}, {16'd0, e.ctrl});
        check($sformatf("done#%0d", seq), {31'd0, bus0.inst_done_o}, {31'd0, e.done});
        check($sformatf("illegal#%0d", seq), {31'd0, bus0.illegal_o}, {31'd0, e.ill});
      end else begin
        check($sformatf("b_state#%0d", seq), {28'd0, bus1.state_o}, {28'd0, e.state});
        check($sformatf("b_ctrl#%0d", seq), {16'd0, ctrl1}, {16'd0, e.ctrl});
        check($sformatf("b_done#%0d", seq), {31'd0, bus1.inst_done_o}, {31'd0, e.done});
        check($sformatf("b_illegal#%0d", seq), {31'd0, bus1.illegal_o}, {31'd0, e.ill});
      end
      seq++;
    end
  end

  // Drive one cycle of stimulus and push what the DUT must show during it.
  task automatic cyc(input bit sel, input bit st, input logic [5:0] op, input bit rdy,
                     input logic [3:0] es, input logic [15:0] ec, input bit ed, input bit ei);
    exp_t e;
    if (sel == 1'b0) begin
      bus0.start_i = st; bus0.Op_i = op; bus0.mem_ready_i = rdy;
    end else begin
      bus1.start_i = st; bus1.Op_i = op; bus1.mem_ready_i = rdy;
    end
    e.sel = sel; e.state = es; e.ctrl = ec; e.done = ed; e.ill = ei;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus0.start_i = 1'b0; bus0.Op_i = '0; bus0.mem_ready_i = 1'b0;
    bus1.start_i = 1'b0; bus1.Op_i = '0; bus1.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'd0, bus0.state_o}, 32'd0);
    check("rst_ctrl", {16'd0, ctrl0}, 32'd0);
    check("rst_illegal", {31'd0, bus0.illegal_o}, 32'd0);
    check("rst_state_b", {28'd0, bus1.state_o}, 32'd0);
    rst = 1'b1;

    // LW, zero-wait: 5 cycles
    cyc(0, 1, DC,     1, S_IDLE,   C_NONE,   0, 0);
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_LW,   1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, DC,     1, S_MADDR,  C_MADDR,  0, 0);
    cyc(0, 1, DC,     1, S_MREAD,  C_MREAD,  0, 0);
    cyc(0, 1, DC,     1, S_MWB,    C_MWB,    1, 0);
    // J with a 3-cycle FETCH stall
    cyc(0, 1, DC,     0, S_FETCH,  C_FSTALL, 0, 0);
    cyc(0, 1, DC,     0, S_FETCH,  C_FSTALL, 0, 0);
    cyc(0, 1, DC,     0, S_FETCH,  C_FSTALL, 0, 0);
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_J,    1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, DC,     1, S_JMP,    C_JMP,    1, 0);
    // RTYPE then BEQ back-to-back; live Op_i disturbed after DECODE
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_R,    1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, O_ADDI, 1, S_EXEC,   C_EXEC_R, 0, 0);
    cyc(0, 1, DC,     1, S_RWB,    C_RWB,    1, 0);
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_BEQ,  1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, DC,     1, S_BR,     C_BR,     1, 0);
    // ADDI
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_ADDI, 1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, O_R,    1, S_EXEC,   C_EXEC_I, 0, 0);
    cyc(0, 1, DC,     1, S_AWB,    C_AWB,    1, 0);
    // SW, start dropped during MEM_WRITE, ready delayed 2 cycles
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_SW,   1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, O_LW,   1, S_MADDR,  C_MADDR,  0, 0);
    cyc(0, 0, DC,     0, S_MWRITE, C_MWRITE, 0, 0);
    cyc(0, 0, DC,     0, S_MWRITE, C_MWRITE, 0, 0);
    cyc(0, 0, DC,     1, S_MWRITE, C_MWRITE, 1, 0);
    cyc(0, 0, DC,     1, S_IDLE,   C_NONE,   0, 0);
    cyc(0, 0, DC,     1, S_IDLE,   C_NONE,   0, 0);
    // LW with one MEM_READ stall, ends in IDLE
    cyc(0, 1, DC,     1, S_IDLE,   C_NONE,   0, 0);
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_LW,   1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, DC,     1, S_MADDR,  C_MADDR,  0, 0);
    cyc(0, 1, DC,     0, S_MREAD,  C_MREAD,  0, 0);
    cyc(0, 1, DC,     1, S_MREAD,  C_MREAD,  0, 0);
    cyc(0, 0, DC,     1, S_MWB,    C_MWB,    1, 0);
    cyc(0, 0, DC,     1, S_IDLE,   C_NONE,   0, 0);
    // Reset asserted mid-EXECUTE
    cyc(0, 1, DC,     1, S_IDLE,   C_NONE,   0, 0);
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_R,    1, S_DEC,    C_DEC,    0, 0);
    #2;
    check("pre_rst_exec", {28'd0, bus0.state_o}, {28'd0, S_EXEC});
    rst = 1'b0;
    #1;
    check("async_rst_state", {28'd0, bus0.state_o}, 32'd0);
    check("async_rst_ctrl", {16'd0, ctrl0}, 32'd0);
    check("async_rst_done", {31'd0, bus0.inst_done_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus0.start_i = 1'b1;
    check("post_rst_idle", {28'd0, bus0.state_o}, 32'd0);
    @(posedge clk); #1;
    check("post_rst_fetch", {28'd0, bus0.state_o}, {28'd0, S_FETCH});
    // Illegal opcode, ILLEGAL_HALT=1
    cyc(0, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(0, 1, O_BAD,  1, S_DEC,    C_DEC,    0, 0);
    cyc(0, 1, DC,     1, S_HALT,   C_NONE,   0, 1);
    cyc(0, 1, O_LW,   1, S_HALT,   C_NONE,   0, 1);
    cyc(0, 1, DC,     1, S_HALT,   C_NONE,   0, 1);
    // Illegal opcode, ILLEGAL_HALT=0: retire at DECODE, run on
    cyc(1, 1, DC,     1, S_IDLE,   C_NONE,   0, 0);
    cyc(1, 1, DC,     1, S_FETCH,  C_FGO,    0, 0);
    cyc(1, 1, O_BAD,  1, S_DEC,    C_DEC,    1, 0);
    cyc(1, 1, DC,     1, S_FETCH,  C_FGO,    0, 1);
    cyc(1, 1, O_J,    1, S_DEC,    C_DEC,    0, 1);
    cyc(1, 0, DC,     1, S_JMP,    C_JMP,    1, 1);
    cyc(1, 0, DC,     1, S_IDLE,   C_NONE,   0, 1);
    // Only reset clears the sticky flag and leaves HALT
    rst = 1'b0;
    #1;
    check("clr_illegal", {31'd0, bus0.illegal_o}, 32'd0);
    check("clr_illegal_b", {31'd0, bus1.illegal_o}, 32'd0);
    check("halt_exit", {28'd0, bus0.state_o}, 32'd0);
    if (sb_q.size() != 0) check("queue_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
